fwd_arb_rr: RTL and testbench

Parametrised successor to the forwarder-side arbiter: connects N packetfilter cores to one forwarder with fair round-robin grant instead of fixed tag-tree priority. It also aligns the read-data mux select with a configurable packet-memory read latency, and holds the grant until outstanding reads drain. It sits between the parallel packetfilter cores and the forwarder, replacing the tag-tree/mux-tree pair on the forward path.

---
 rtl/fwd_arb_rr_pkg.sv | 13 +
 rtl/fwd_arb_rr_if.sv | 39 +++
 rtl/fwd_arb_rr_picker.sv | 37 +++
 rtl/fwd_arb_rr.sv | 144 ++++++++++++++
 tb/tb_fwd_arb_rr.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_arb_rr_pkg.sv
// Shared types for the forwarder-side round-robin arbiter.
// Holds the arbiter FSM encoding and the drain-counter width.
package fwd_arb_rr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int CNT_W = 3;

endpackage

// File: rtl/fwd_arb_rr_if.sv
// Forwarder/core bundle around fwd_arb_rr; slave is the arbiter's view.
// Master is the environment: the forwarder plus the packetfilter cores.
interface fwd_arb_rr_if #(
  parameter int N  = 4,
  parameter int AW = 8,
  parameter int DW = 64,
  parameter int PW = 32,
  parameter int SW = $clog2(N)
);
  logic [AW-1:0]   addr;
  logic            rd_en;
  logic [DW-1:0]   rd_data;
  logic            rd_data_vld;
  logic [PW-1:0]   byte_len;
  logic            done;
  logic            rdy;
  logic            ack;
  logic [AW-1:0]   fwd_addr;
  logic [N-1:0]    fwd_rd_en;
  logic [N*DW-1:0] fwd_rd_data;
  logic [N-1:0]    fwd_rd_data_vld;
  logic [N*PW-1:0] fwd_byte_len;
  logic [N-1:0]    fwd_done;
  logic [N-1:0]    rdy_for_fwd;
  logic [N-1:0]    rdy_for_fwd_ack;
  logic [SW-1:0]   sel;

  modport slave (
    input  addr, rd_en, done, ack, fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd,
    output rd_data, rd_data_vld, byte_len, rdy, fwd_addr, fwd_rd_en, fwd_done,
           rdy_for_fwd_ack, sel
  );

  modport master (
    output addr, rd_en, done, ack, fwd_rd_data, fwd_rd_data_vld, fwd_byte_len, rdy_for_fwd,
    input  rd_data, rd_data_vld, byte_len, rdy, fwd_addr, fwd_rd_en, fwd_done,
           rdy_for_fwd_ack, sel
  );
endinterface

// File: rtl/fwd_arb_rr_picker.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// Purely combinational; no backpressure.
module fwd_arb_rr_picker #(
  parameter int N         = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [N-1:0]         req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] pick,
  output logic                 any_vld
);

  logic [N-1:0] rot;
  int           base;
  int           off;
  int           unrot;

  always_comb begin
    base  = int'(ptr);
    rot   = '0;
    off   = 0;
    unrot = 0;
    // rotate so that the pointer position becomes bit 0
    for (int j = 0; j < N; j++) begin
      if (base + j >= N) rot[j] = req[base + j - N];
      else               rot[j] = req[base + j];
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    unrot = base + off;
    if (unrot >= N) unrot = unrot - N;
    pick    = SEL_WIDTH'(unrot);
    any_vld = |req;
  end

endmodule

// File: rtl/fwd_arb_rr.sv
// Round-robin arbiter joining N packetfilter cores to one forwarder; grant held until reads drain.
// Grant is combinational with rdy&&ack; read data lags rd_en by MEM_LAT; rdy stays low while a packet is owned.
module fwd_arb_rr
  import fwd_arb_rr_pkg::*;
#(
  parameter int N                  = 4,
  parameter int PACKMEM_ADDR_WIDTH = 8,
  parameter int PACKMEM_DATA_WIDTH = 64,
  parameter int PLEN_WIDTH         = 32,
  parameter int MEM_LAT            = 1,
  parameter int SEL_WIDTH          = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  fwd_arb_rr_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;

  state_e               state;
  state_e               state_nxt;
  logic [SEL_WIDTH-1:0] ptr;
  logic [SEL_WIDTH-1:0] sel;
  logic [SEL_WIDTH-1:0] pick;
  logic [SEL_WIDTH-1:0] sel_d;
  logic                 gv_d;
  logic                 any_vld;
  logic                 hs;
  logic [CNT_W-1:0]     cnt;
  logic                 rdy_c;
  logic [N-1:0]         ack_c;
  logic [N-1:0]         ren_c;
  logic [N-1:0]         done_c;

  logic [PACKMEM_ADDR_WIDTH-1:0] addr_w;
  logic [PACKMEM_DATA_WIDTH-1:0] data_arr [N];
  logic [PLEN_WIDTH-1:0]         len_arr  [N];

  fwd_arb_rr_picker #(
    .N         (N),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_picker (
    .req     (bus.rdy_for_fwd),
    .ptr     (ptr),
    .pick    (pick),
    .any_vld (any_vld)
  );

  assign hs = (state == IDLE) && any_vld && bus.ack;

  always_comb begin
    state_nxt = state;
    rdy_c     = 1'b0;
    ack_c     = '0;
    ren_c     = '0;
    done_c    = '0;
    unique case (state)
      IDLE: begin
        rdy_c = any_vld;
        if (hs) begin
          ack_c[pick] = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        ren_c[sel]  = bus.rd_en;
        done_c[sel] = bus.done;
        if (bus.done) state_nxt = (MEM_LAT == 0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (cnt == CNT_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a reset cycle abandons any grant without telling the core
    if (rst) begin
      rdy_c  = 1'b0;
      ack_c  = '0;
      ren_c  = '0;
      done_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        sel <= pick;
        ptr <= (pick == SEL_WIDTH'(N - 1)) ? '0 : pick + 1'b1;
      end
      cnt <= (state == DRAIN) ? cnt + 1'b1 : '0;
    end
  end

  // sel_d tracks which core's data is returning MEM_LAT cycles after its read
  generate
    if (MEM_LAT == 0) begin : g_nolat
      assign sel_d = sel;
      assign gv_d  = (state == BUSY);
    end else begin : g_lat
      logic [SEL_WIDTH-1:0] sel_sr [MEM_LAT];
      logic [MEM_LAT-1:0]   gv_sr;

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < MEM_LAT; k++) sel_sr[k] <= '0;
          gv_sr <= '0;
        end else begin
          sel_sr[0] <= sel;
          gv_sr[0]  <= (state == BUSY);
          for (int k = 1; k < MEM_LAT; k++) begin
            sel_sr[k] <= sel_sr[k-1];
            gv_sr[k]  <= gv_sr[k-1];
          end
        end
      end

      assign sel_d = sel_sr[MEM_LAT-1];
      assign gv_d  = gv_sr[MEM_LAT-1];
    end
  endgenerate

  for (genvar g = 0; g < N; g++) begin : g_slice
    assign data_arr[g] = bus.fwd_rd_data[g*PACKMEM_DATA_WIDTH +: PACKMEM_DATA_WIDTH];
    assign len_arr[g]  = bus.fwd_byte_len[g*PLEN_WIDTH +: PLEN_WIDTH];
  end

  assign addr_w              = bus.addr;
  assign bus.fwd_addr        = addr_w;
  assign bus.rd_data         = data_arr[sel_d];
  assign bus.rd_data_vld     = !rst && gv_d && bus.fwd_rd_data_vld[sel_d];
  assign bus.byte_len        = len_arr[sel];
  assign bus.rdy             = rdy_c;
  assign bus.rdy_for_fwd_ack = ack_c;
  assign bus.fwd_rd_en       = ren_c;
  assign bus.fwd_done        = done_c;
  assign bus.sel             = sel;

endmodule

// File: tb/tb_fwd_arb_rr.sv
// Bench for fwd_arb_rr: table vectors, randomized run against a queue-based model, directed corners.
// DUT a uses MEM_LAT=1 and is model-checked; DUT b uses MEM_LAT=2 for the drain sequence.
module tb_fwd_arb_rr;

  localparam int N   = 4;
  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int PW  = 32;
  localparam int SW  = 2;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fwd_arb_rr_if #(.N(N), .AW(AW), .DW(DW), .PW(PW), .SW(SW)) ifa ();
  fwd_arb_rr_if #(.N(N), .AW(AW), .DW(DW), .PW(PW), .SW(SW)) ifb ();

  fwd_arb_rr #(
    .N(N), .PACKMEM_ADDR_WIDTH(AW), .PACKMEM_DATA_WIDTH(DW), .PLEN_WIDTH(PW),
    .MEM_LAT(LAT), .SEL_WIDTH(SW)
  ) u_dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  fwd_arb_rr #(
    .N(N), .PACKMEM_ADDR_WIDTH(AW), .PACKMEM_DATA_WIDTH(DW), .PLEN_WIDTH(PW),
    .MEM_LAT(2), .SEL_WIDTH(SW)
  ) u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

  typedef struct packed {
    logic       r;
    logic [3:0] rfw;
    logic       a;
    logic       re;
    logic       d;
    logic       e_rdy;
    logic [3:0] e_ack;
    logic [3:0] e_ren;
    logic [3:0] e_done;
    logic [1:0] e_sel;
  } vec_t;

  vec_t tbl [23];

  // reference model: owner flag, owning core, pointer, drain cycles left, grant history
  int m_busy, m_sel, m_ptr, m_drain;
  int hb[$];
  int hs[$];
  int c_pick;
  bit c_idle, c_hs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_sel = 0; m_ptr = 0; m_drain = 0;
    hb.delete(); hs.delete();
    for (int k = 0; k < LAT; k++) begin
      hb.push_back(0);
      hs.push_back(0);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic a, input logic re, input logic d);
    rst = r; ifa.rdy_for_fwd = q; ifa.ack = a; ifa.rd_en = re; ifa.done = d;
  endtask

  task automatic rnd_data();
    ifa.addr = AW'($urandom);
    for (int i = 0; i < N; i++) begin
      ifa.fwd_rd_data[i*DW +: DW]  = {$urandom, $urandom};
      ifa.fwd_byte_len[i*PW +: PW] = $urandom;
    end
    ifa.fwd_rd_data_vld = N'($urandom);
  endtask

  task automatic eval_cycle();
    logic [N-1:0] e_ack, e_ren, e_done;
    logic         e_rdy, e_vld;
    @(negedge clk);
    c_pick = -1;
    for (int j = 0; j < N; j++) begin
      int idx;
      idx = (m_ptr + j) % N;
      if (c_pick < 0 && ifa.rdy_for_fwd[idx]) c_pick = idx;
    end
    c_idle = (m_busy == 0) && (m_drain == 0);
    e_rdy  = !rst && c_idle && (c_pick >= 0);
    c_hs   = e_rdy && ifa.ack;
    e_ack  = '0;
    if (c_hs) e_ack[c_pick] = 1'b1;
    e_ren  = '0;
    e_done = '0;
    if (!rst && m_busy != 0) begin
      e_ren[m_sel]  = ifa.rd_en;
      e_done[m_sel] = ifa.done;
    end
    e_vld = !rst && (hb[0] != 0) && ifa.fwd_rd_data_vld[hs[0]];
    chk("rdy", ifa.rdy, e_rdy);
    chk("grant", ifa.rdy_for_fwd_ack, e_ack);
    chk("fwd_rd_en", ifa.fwd_rd_en, e_ren);
    chk("fwd_done", ifa.fwd_done, e_done);
    chk("sel", ifa.sel, m_sel);
    chk("byte_len", ifa.byte_len, ifa.fwd_byte_len[m_sel*PW +: PW]);
    chk("fwd_addr", ifa.fwd_addr, ifa.addr);
    chk("rd_data_vld", ifa.rd_data_vld, e_vld);
    if (e_vld) chk("rd_data", ifa.rd_data, ifa.fwd_rd_data[hs[0]*DW +: DW]);
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hb.push_back(m_busy);
      hs.push_back(m_sel);
      void'(hb.pop_front());
      void'(hs.pop_front());
      if (c_idle) begin
        if (c_hs) begin
          m_busy = 1;
          m_sel  = c_pick;
          m_ptr  = (c_pick + 1) % N;
        end
      end else if (m_busy != 0) begin
        if (ifa.done) begin
          m_busy  = 0;
          m_drain = LAT;
        end
      end else begin
        m_drain--;
      end
    end
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    //          r  rfw     a  re d   rdy ack     ren     done    sel
    tbl[0]  = '{1, 4'b1111, 1, 1, 1,  0, 4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[1]  = '{0, 4'b0000, 1, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[2]  = '{0, 4'b1111, 1, 0, 0,  1, 4'b0001, 4'b0000, 4'b0000, 2'd0};
    tbl[3]  = '{0, 4'b1111, 1, 1, 0,  0, 4'b0000, 4'b0001, 4'b0000, 2'd0};
    tbl[4]  = '{0, 4'b1111, 0, 1, 1,  0, 4'b0000, 4'b0001, 4'b0001, 2'd0};
    tbl[5]  = '{0, 4'b1111, 1, 1, 1,  0, 4'b0000, 4'b0000, 4'b0000, 2'd0};
    tbl[6]  = '{0, 4'b1111, 1, 0, 0,  1, 4'b0010, 4'b0000, 4'b0000, 2'd1};
    tbl[7]  = '{0, 4'b0000, 0, 1, 1,  0, 4'b0000, 4'b0010, 4'b0010, 2'd1};
    tbl[8]  = '{0, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd1};
    tbl[9]  = '{0, 4'b0100, 1, 0, 0,  1, 4'b0100, 4'b0000, 4'b0000, 2'd2};
    tbl[10] = '{0, 4'b0100, 0, 0, 1,  0, 4'b0000, 4'b0000, 4'b0100, 2'd2};
    tbl[11] = '{0, 4'b0100, 1, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd2};
    tbl[12] = '{0, 4'b0100, 0, 0, 0,  1, 4'b0000, 4'b0000, 4'b0000, 2'd2};
    tbl[13] = '{0, 4'b0100, 1, 0, 0,  1, 4'b0100, 4'b0000, 4'b0000, 2'd2};
    tbl[14] = '{0, 4'b0100, 1, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd2};
    tbl[15] = '{0, 4'b0100, 0, 0, 1,  0, 4'b0000, 4'b0000, 4'b0100, 2'd2};
    tbl[16] = '{0, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd2};
    tbl[17] = '{0, 4'b1000, 1, 0, 0,  1, 4'b1000, 4'b0000, 4'b0000, 2'd3};
    tbl[18] = '{0, 4'b0000, 0, 0, 1,  0, 4'b0000, 4'b0000, 4'b1000, 2'd3};
    tbl[19] = '{0, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd3};
    tbl[20] = '{0, 4'b1111, 1, 0, 0,  1, 4'b0001, 4'b0000, 4'b0000, 2'd0};
    tbl[21] = '{0, 4'b0000, 0, 0, 1,  0, 4'b0000, 4'b0000, 4'b0001, 2'd0};
    tbl[22] = '{0, 4'b0000, 0, 0, 0,  0, 4'b0000, 4'b0000, 4'b0000, 2'd0};

    rst_b = 1'b1;
    ifb.addr = '0; ifb.rd_en = 1'b0; ifb.done = 1'b0; ifb.ack = 1'b0;
    ifb.fwd_rd_data = '0; ifb.fwd_rd_data_vld = '0; ifb.fwd_byte_len = '0; ifb.rdy_for_fwd = '0;
    model_reset();
    drive(1, 4'b0000, 0, 0, 0);
    rnd_data();
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].r, tbl[i].rfw, tbl[i].a, tbl[i].re, tbl[i].d);
      rnd_data();
      eval_cycle();
      chk("tbl_rdy", ifa.rdy, tbl[i].e_rdy);
      chk("tbl_grant", ifa.rdy_for_fwd_ack, tbl[i].e_ack);
      chk("tbl_fwd_rd_en", ifa.fwd_rd_en, tbl[i].e_ren);
      chk("tbl_fwd_done", ifa.fwd_done, tbl[i].e_done);
      advance();
      chk("tbl_sel", ifa.sel, tbl[i].e_sel);
    end

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(63) == 0), N'($urandom), 1'($urandom_range(1)),
            1'($urandom_range(1)), ($urandom_range(7) == 0));
      rnd_data();
      eval_cycle();
      advance();
    end

    // byte length and read-data alignment for core 1
    drive(1, 4'b0000, 0, 0, 0); eval_cycle(); advance();
    rnd_data();
    ifa.fwd_byte_len[PW +: PW] = 32'd60;
    drive(0, 4'b0010, 1, 0, 0); eval_cycle(); advance();
    chk("len_after_ack", ifa.byte_len, 32'd60);
    chk("sel_after_ack", ifa.sel, 2'd1);
    drive(0, 4'b0000, 0, 1, 0); ifa.addr = 8'h21;
    eval_cycle();
    chk("d1_rd_en", ifa.fwd_rd_en, 4'b0010);
    advance();
    drive(0, 4'b0000, 0, 0, 0);
    ifa.fwd_rd_data[DW +: DW] = 64'hC0DE_0000_0000_0021;
    ifa.fwd_rd_data_vld = 4'b0010;
    eval_cycle();
    chk("d1_vld", ifa.rd_data_vld, 1'b1);
    chk("d1_data", ifa.rd_data, 64'hC0DE_0000_0000_0021);
    advance();
    drive(0, 4'b0000, 0, 1, 1);
    eval_cycle();
    chk("d1_done", ifa.fwd_done, 4'b0010);
    chk("d1_rd_en_last", ifa.fwd_rd_en, 4'b0010);
    advance();
    drive(0, 4'b1111, 1, 1, 0);
    ifa.fwd_rd_data[DW +: DW] = 64'hC0DE_0000_0000_0022;
    ifa.fwd_rd_data_vld = 4'b1111;
    eval_cycle();
    chk("d1_drain_vld", ifa.rd_data_vld, 1'b1);
    chk("d1_drain_data", ifa.rd_data, 64'hC0DE_0000_0000_0022);
    chk("d1_drain_rd_en", ifa.fwd_rd_en, 4'b0000);
    chk("d1_drain_rdy", ifa.rdy, 1'b0);
    advance();
    drive(0, 4'b1111, 0, 0, 0);
    eval_cycle();
    chk("d1_rdy_again", ifa.rdy, 1'b1);
    advance();

    // reset while core 1 owns the forwarder
    drive(1, 4'b0000, 0, 0, 0); eval_cycle(); advance();
    drive(0, 4'b0010, 1, 0, 0); eval_cycle(); advance();
    drive(1, 4'b1111, 0, 1, 1);
    ifa.fwd_rd_data_vld = 4'b1111;
    eval_cycle();
    chk("rst_done", ifa.fwd_done, 4'b0000);
    chk("rst_rd_en", ifa.fwd_rd_en, 4'b0000);
    chk("rst_rdy", ifa.rdy, 1'b0);
    chk("rst_vld", ifa.rd_data_vld, 1'b0);
    advance();
    drive(0, 4'b1111, 0, 1, 1);
    eval_cycle();
    chk("post_rst_rdy", ifa.rdy, 1'b1);
    chk("post_rst_done", ifa.fwd_done, 4'b0000);
    advance();
    drive(0, 4'b1111, 1, 0, 0);
    eval_cycle();
    chk("post_rst_ptr0", ifa.rdy_for_fwd_ack, 4'b0001);
    advance();

    // MEM_LAT=2: two drain cycles, reads gated, last read still returned
    rst_b = 1'b0;
    ifb.rdy_for_fwd = 4'b0001; ifb.ack = 1'b1;
    @(negedge clk);
    chk("b_grant", ifb.rdy_for_fwd_ack, 4'b0001);
    @(posedge clk); #1;
    ifb.ack = 1'b0; ifb.rd_en = 1'b1; ifb.done = 1'b1;
    @(negedge clk);
    chk("b_done", ifb.fwd_done, 4'b0001);
    chk("b_rd_en", ifb.fwd_rd_en, 4'b0001);
    @(posedge clk); #1;
    ifb.rdy_for_fwd = 4'b1111; ifb.done = 1'b0; ifb.fwd_rd_data_vld = 4'b1111;
    @(negedge clk);
    chk("b_drain1_rdy", ifb.rdy, 1'b0);
    chk("b_drain1_rd_en", ifb.fwd_rd_en, 4'b0000);
    chk("b_drain1_vld", ifb.rd_data_vld, 1'b0);
    @(posedge clk); #1;
    ifb.fwd_rd_data[0 +: DW] = 64'hB0B0_0000_0000_0002;
    @(negedge clk);
    chk("b_drain2_rdy", ifb.rdy, 1'b0);
    chk("b_drain2_rd_en", ifb.fwd_rd_en, 4'b0000);
    chk("b_drain2_vld", ifb.rd_data_vld, 1'b1);
    chk("b_drain2_data", ifb.rd_data, 64'hB0B0_0000_0000_0002);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b_idle_rdy", ifb.rdy, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
